baud_tick_gen: RTL and testbench
================================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9_600, meaning the reset-time baud rate.
REQ-003 SHALL have parameter OSR, default 16, meaning receive oversample ratio; even, 4..64.
REQ-004 SHALL have parameter DIV_W, default 16, meaning integer divisor width.
REQ-005 SHALL have parameter FRAC_W, default 4, meaning fractional divisor width.
REQ-006 SHALL derive RST_DIV_INT = floor(CLK_HZ/(BAUD*OSR)) and RST_DIV_FRAC = floor(frac(CLK_HZ/(BAUD*OSR))*2^FRAC_W).
REQ-007 SHALL have port clk, input, 1, system clock, all logic on rising edge.
REQ-008 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port en, input, 1, generator run enable.
REQ-010 SHALL have port div_int, input, DIV_W, integer clocks per oversample tick.
REQ-011 SHALL have port div_frac, input, FRAC_W, fractional clocks per tick in units of 2^-FRAC_W.
REQ-012 SHALL have port div_load, input, 1, single-cycle strobe capturing div_int/div_frac.
REQ-013 SHALL have port rx_resync, input, 1, start-bit edge strobe realigning receive phase.
REQ-014 SHALL have port rx_tick, output, 1, one-cycle oversample enable pulse.
REQ-015 SHALL have port rx_mid, output, 1, one-cycle pulse at receive bit centre.
REQ-016 SHALL have port tx_tick, output, 1, one-cycle pulse per bit period (every OSR rx_ticks).
REQ-017 SHALL have port div_err, output, 1, sticky flag for a rejected divisor load.

Function
REQ-018 SHALL produce single-cycle enable pulses on clk, never derived/toggled clocks.
REQ-019 SHALL hold active divisor registers (act_int, act_frac), a down-counter cnt, a FRAC_W-bit accumulator acc, a tx counter os_cnt (0..OSR-1) and an rx phase counter rx_ph (0..OSR-1).
REQ-020 SHALL decode rx_tick = en and cnt==0, from registered state only.
REQ-021 SHALL, on each rx_tick, compute {c,acc} = acc + act_frac and reload cnt = act_int-1+c; otherwise decrement cnt while en is high.
REQ-022 SHALL therefore yield a mean tick period of act_int + act_frac/2^FRAC_W clocks, each period being act_int or act_int+1 clocks.
REQ-023 SHALL, while en is low, hold cnt=act_int-1, acc=0, os_cnt=0, rx_ph=0 and keep all pulse outputs low.
REQ-024 SHALL assert the first rx_tick on the act_int-th cycle en is sampled high.
REQ-025 SHALL assert tx_tick on an rx_tick with os_cnt==OSR-1; os_cnt increments on every rx_tick and wraps OSR-1 to 0.
REQ-026 SHALL assert rx_mid on an rx_tick with rx_ph==OSR/2-1; rx_ph increments on every rx_tick and wraps OSR-1 to 0.
REQ-027 SHALL, on rx_resync, clear rx_ph to 0; cnt, acc and os_cnt are unaffected, so tx timing never jitters.
REQ-028 SHALL, when rx_resync coincides with rx_tick, clear rx_ph to 0 (not 1) and suppress rx_mid in that cycle.
REQ-029 SHALL, on div_load with div_int>=2, store the values in shadow registers and clear div_err.
REQ-030 SHALL copy shadow to active at the next cnt reload; the in-flight period completes unchanged.
REQ-031 SHALL, when en is low, copy div_load values to active immediately (same edge).
REQ-032 SHALL, on div_load with div_int<2, leave shadow and active unchanged and set div_err until the next valid load.
REQ-033 SHALL ignore rx_resync while en is low.

Reset
REQ-034 SHALL, on rst_n low, asynchronously set act/shadow to RST_DIV_INT/RST_DIV_FRAC, cnt=RST_DIV_INT-1, acc=0, os_cnt=0, rx_ph=0, div_err=0; rx_tick, rx_mid and tx_tick are low.
REQ-035 SHALL, on reset assertion mid-period, discard the period; after release the first rx_tick follows REQ-024.

Verification
REQ-036 SHALL check: defaults, release reset, en=1 -> rx_tick every 651 clocks (div 651, frac 0); tx_tick every 10416 clocks; rx_mid every 10416 clocks.
REQ-037 SHALL check: en=0, load div_int=4 and frac=8 with FRAC_W=4, then en=1 -> rx_tick intervals 4,4,5,4,5; 32 ticks in 144 clocks.
REQ-038 SHALL check: OSR=16, div=4, en=1, pulse rx_resync in a non-tick cycle -> rx_mid on the 8th subsequent rx_tick, then every 16 ticks; tx_tick cadence unchanged.
REQ-039 SHALL check: rx_resync in the same cycle as rx_tick -> no rx_mid that cycle; next rx_mid on the 8th following tick.
REQ-040 SHALL check: running div=10, load div_int=6 mid-period -> current period is 10 clocks, the next is 6; then load div_int=1 -> div_err=1, period stays 6; valid load clears div_err.
REQ-041 SHALL check: rst_n pulsed low mid-period -> outputs low immediately; first rx_tick RST_DIV_INT cycles after release with en=1.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: oversample enable (rx_tick), receive bit-centre
// strobe (rx_mid) and transmit bit strobe (tx_tick), all as single-cycle enables on clk.
module baud_tick_gen #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9_600,
    parameter int OSR    = 16,
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              rx_resync,
    output logic              rx_tick,
    output logic              rx_mid,
    output logic              tx_tick,
    output logic              div_err
);

    localparam longint DEN = longint'(BAUD) * longint'(OSR);
    localparam longint RST_Q = longint'(CLK_HZ) / DEN;
    localparam longint RST_R = longint'(CLK_HZ) % DEN;
    localparam logic [DIV_W-1:0]  RST_DIV_INT  = DIV_W'(RST_Q);
    localparam logic [FRAC_W-1:0] RST_DIV_FRAC = FRAC_W'((RST_R << FRAC_W) / DEN);
    localparam int PH_W = $clog2(OSR);

    function automatic logic [PH_W-1:0] ph_inc(input logic [PH_W-1:0] p);
        return (p == PH_W'(OSR - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [DIV_W-1:0]  act_int, sh_int, cnt, nxt_int;
    logic [FRAC_W-1:0] act_frac, sh_frac, acc, nxt_frac;
    logic [FRAC_W:0]   frac_sum;
    logic [PH_W-1:0]   os_cnt, rx_ph;
    logic              load_ok;

    assign load_ok  = div_load && (div_int >= DIV_W'(2));
    assign nxt_int  = load_ok ? div_int  : sh_int;
    assign nxt_frac = load_ok ? div_frac : sh_frac;
    assign frac_sum = {1'b0, acc} + {1'b0, act_frac};

    assign rx_tick = en && (cnt == '0);
    assign tx_tick = rx_tick && (os_cnt == PH_W'(OSR - 1));
    assign rx_mid  = rx_tick && !rx_resync && (rx_ph == PH_W'(OSR / 2 - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_int  <= RST_DIV_INT;
            act_frac <= RST_DIV_FRAC;
            sh_int   <= RST_DIV_INT;
            sh_frac  <= RST_DIV_FRAC;
            cnt      <= RST_DIV_INT - DIV_W'(1);
            acc      <= '0;
            os_cnt   <= '0;
            rx_ph    <= '0;
            div_err  <= 1'b0;
        end else begin
            if (load_ok) begin
                sh_int  <= div_int;
                sh_frac <= div_frac;
                div_err <= 1'b0;
            end else if (div_load) begin
                div_err <= 1'b1;
            end

            if (!en) begin
                act_int  <= nxt_int;
                act_frac <= nxt_frac;
                cnt      <= nxt_int - DIV_W'(1);
                acc      <= '0;
                os_cnt   <= '0;
                rx_ph    <= '0;
            end else if (rx_tick) begin
                // Carry out of the fractional accumulator stretches the next period by one clock
                cnt    <= act_int - DIV_W'(1) + DIV_W'(frac_sum[FRAC_W]);
                acc    <= frac_sum[FRAC_W-1:0];
                os_cnt <= ph_inc(os_cnt);
                rx_ph  <= rx_resync ? '0 : ph_inc(rx_ph);
            end else begin
                // cnt already holds the in-flight period, so active may follow shadow here
                act_int  <= nxt_int;
                act_frac <= nxt_frac;
                cnt      <= cnt - DIV_W'(1);
                if (rx_resync)
                    rx_ph <= '0;
            end
        end
    end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: cycle-level arithmetic model compared every cycle,
// plus directed scenarios with hand-computed interval expectations.
module tb_baud_tick_gen;

    localparam int OSR   = 16;
    localparam int FW    = 4;
    localparam int RST_D = 651;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_load = 1'b0;
    logic        rx_resync = 1'b0;
    logic        rx_tick, rx_mid, tx_tick, div_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    baud_tick_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_int   (div_int),
        .div_frac  (div_frac),
        .div_load  (div_load),
        .rx_resync (rx_resync),
        .rx_tick   (rx_tick),
        .rx_mid    (rx_mid),
        .tx_tick   (tx_tick),
        .div_err   (div_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model state: absolute cycle numbers, cumulative fraction sum, tick counts
    int cyc = 0, nt = 0, fsum = 0, en_start = 0, rs_cyc = -1, ld_cyc = -1;
    int n_tk = 0, m_tk = 0, pd = RST_D, pf = 0;
    bit run = 1'b0, err_m = 1'b0;
    int tq[$], txq[$], mq[$];

    always @(negedge clk) begin
        bit e_tick, e_tx, e_mid, e_err;
        int s_old;
        cyc++;
        e_tick = 1'b0; e_tx = 1'b0; e_mid = 1'b0;
        e_err = err_m;
        if (!rst_n) begin
            run = 1'b0; pd = RST_D; pf = 0; err_m = 1'b0; e_err = 1'b0;
        end else begin
            if (en) begin
                if (!run) begin
                    run = 1'b1; nt = cyc + pd - 1; fsum = 0; n_tk = 0; m_tk = 0; en_start = cyc;
                end
                e_tick = (cyc == nt);
                e_tx   = e_tick && (n_tk % OSR == OSR - 1);
                e_mid  = e_tick && !rx_resync && (m_tk % OSR == OSR / 2 - 1);
                if (e_tick) begin
                    s_old = fsum;
                    fsum  = fsum + pf;
                    nt    = cyc + pd + (fsum >> FW) - (s_old >> FW);
                    n_tk++;
                    m_tk++;
                end
                if (rx_resync) begin
                    m_tk = 0; rs_cyc = cyc;
                end
            end else begin
                run = 1'b0;
            end
            if (div_load) begin
                ld_cyc = cyc;
                if (div_int >= 16'd2) begin
                    pd = int'(div_int); pf = int'(div_frac); err_m = 1'b0;
                end else begin
                    err_m = 1'b1;
                end
            end
        end
        chk("rx_tick", int'(rx_tick), int'(e_tick));
        chk("tx_tick", int'(tx_tick), int'(e_tx));
        chk("rx_mid",  int'(rx_mid),  int'(e_mid));
        chk("div_err", int'(div_err), int'(e_err));
        if (rx_tick) tq.push_back(cyc);
        if (tx_tick) txq.push_back(cyc);
        if (rx_mid)  mq.push_back(cyc);
    end

    function automatic int at(input int which, input int i);
        case (which)
            0:       return (i >= 0 && i < tq.size())  ? tq[i]  : -1;
            1:       return (i >= 0 && i < txq.size()) ? txq[i] : -1;
            default: return (i >= 0 && i < mq.size())  ? mq[i]  : -1;
        endcase
    endfunction

    function automatic int tick_idx_after(input int c);
        foreach (tq[i]) if (tq[i] > c) return i;
        return -1;
    endfunction

    function automatic int ticks_to_mid(input int c);
        int mid1 = -1;
        int k = 0;
        foreach (mq[i]) if (mq[i] > c && mid1 < 0) mid1 = mq[i];
        if (mid1 < 0) return -1;
        foreach (tq[i]) if (tq[i] > c && tq[i] <= mid1) k++;
        return k;
    endfunction

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic load(input int d, input int f);
        div_int = 16'(d); div_frac = 4'(f); div_load = 1'b1;
        step(1);
        div_load = 1'b0;
    endtask

    task automatic clear_q();
        tq.delete(); txq.delete(); mq.delete();
    endtask

    // sel 0 waits for rx_tick, 1 for rx_mid; bounded
    task automatic wait_sig(input int sel, input string name);
        int k = 0;
        while (((sel == 0) ? rx_tick : rx_mid) !== 1'b1 && k < 2000) begin
            step(1);
            k++;
        end
        if (((sel == 0) ? rx_tick : rx_mid) !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s: timed out after %0d cycles", name, k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int iv[4];
        int c, bad, i0;
        rst_n = 1'b0;
        step(3);
        chk("reset_rx_tick", int'(rx_tick), 0);
        chk("reset_tx_tick", int'(tx_tick), 0);
        chk("reset_rx_mid",  int'(rx_mid),  0);
        chk("reset_div_err", int'(div_err), 0);
        rst_n = 1'b1;
        step(2);

        // Defaults: 651-clock ticks, 10416-clock tx and mid
        clear_q();
        en = 1'b1;
        step(21000);
        chk("dflt_first_tick", at(0, 0) - en_start + 1, 651);
        chk("dflt_tick_period", at(0, 1) - at(0, 0), 651);
        chk("dflt_first_tx", at(1, 0) - en_start + 1, 10416);
        chk("dflt_tx_period", at(1, 1) - at(1, 0), 10416);
        chk("dflt_first_mid", at(2, 0) - en_start + 1, 5208);
        chk("dflt_mid_period", at(2, 1) - at(2, 0), 10416);

        // Fractional divisor 4 + 8/16
        en = 1'b0;
        step(2);
        load(4, 8);
        step(1);
        clear_q();
        en = 1'b1;
        step(150);
        chk("frac_iv0", at(0, 0) - en_start + 1, 4);
        iv = '{4, 5, 4, 5};
        for (int i = 0; i < 4; i++) chk($sformatf("frac_iv%0d", i + 1), at(0, i + 1) - at(0, i), iv[i]);
        c = 0;
        foreach (tq[i]) if (tq[i] - en_start < 144) c++;
        chk("frac_ticks_in_144", c, 32);

        // Resync in a non-tick cycle
        en = 1'b0;
        step(1);
        load(4, 0);
        clear_q();
        en = 1'b1;
        step(40);
        wait_sig(0, "resync_wait_tick");
        step(1);
        rx_resync = 1'b1;
        step(1);
        rx_resync = 1'b0;
        step(200);
        chk("resync_ticks_to_mid", ticks_to_mid(rs_cyc), 8);
        i0 = -1;
        foreach (mq[i]) if (mq[i] > rs_cyc && i0 < 0) i0 = i;
        chk("resync_mid_period", at(2, i0 + 1) - at(2, i0), 64);
        bad = 0;
        for (int i = 1; i < txq.size(); i++) if (txq[i] - txq[i-1] != 64) bad++;
        chk("resync_tx_count_ok", (txq.size() >= 3) ? 1 : 0, 1);
        chk("resync_tx_bad_iv", bad, 0);

        // Resync coinciding with a would-be mid tick
        wait_sig(1, "coinc_wait_mid");
        rx_resync = 1'b1;
        #1;
        chk("coinc_mid_suppressed", int'(rx_mid), 0);
        step(1);
        rx_resync = 1'b0;
        step(200);
        c = 0;
        foreach (mq[i]) if (mq[i] == rs_cyc) c++;
        chk("coinc_no_mid_logged", c, 0);
        chk("coinc_ticks_to_mid", ticks_to_mid(rs_cyc), 8);

        // Divisor change while running, then rejected load
        en = 1'b0;
        step(1);
        load(10, 0);
        clear_q();
        en = 1'b1;
        step(25);
        wait_sig(0, "div_wait_tick");
        step(4);
        load(6, 0);
        step(40);
        i0 = tick_idx_after(ld_cyc);
        chk("div_cur_period", at(0, i0) - at(0, i0 - 1), 10);
        chk("div_next_period", at(0, i0 + 1) - at(0, i0), 6);
        load(1, 0);
        step(1);
        chk("div_err_set", int'(div_err), 1);
        step(30);
        chk("div_period_kept", at(0, tq.size() - 1) - at(0, tq.size() - 2), 6);
        load(6, 0);
        step(1);
        chk("div_err_cleared", int'(div_err), 0);

        // Reset mid-period with div_err set beforehand
        load(0, 0);
        step(1);
        wait_sig(0, "rst_wait_tick");
        step(2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rx_tick", int'(rx_tick), 0);
        chk("rst_mid_tx_tick", int'(tx_tick), 0);
        chk("rst_mid_rx_mid",  int'(rx_mid),  0);
        chk("rst_mid_div_err", int'(div_err), 0);
        step(2);
        clear_q();
        rst_n = 1'b1;
        step(700);
        chk("rst_first_tick", at(0, 0) - en_start + 1, 651);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
